wb_reg_master: RTL and testbench



---
 rtl/wb_master_pkg.sv | 21 ++
 rtl/wb_reg_master_if.sv | 48 ++++
 rtl/wb_reg_master.sv | 147 ++++++++++++++
 tb/tb_wb_reg_master.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_pkg.sv
// Shared definitions for the Wishbone register-bank initiator:
// FSM state encoding, response status codes and the bus data width.
package wb_master_pkg;

  localparam int WB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    GAP    = 2'd3
  } state_e;

  typedef logic [1:0] status_t;

  localparam status_t ST_OK      = 2'b00;
  localparam status_t ST_ERR     = 2'b01;
  localparam status_t ST_TIMEOUT = 2'b10;
  localparam status_t ST_RETRY   = 2'b11;

endpackage

// File: rtl/wb_reg_master_if.sv
// Bundle of the command/response handshake and the Wishbone bus seen by
// wb_reg_master. The master modport is the initiator's view; the slave
// modport is the view of whatever sits around it (host side plus bus slave).
interface wb_reg_master_if
  import wb_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
);

  // command / response side
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_we_i;
  logic [ADDR_WIDTH-1:0] cmd_adr_i;
  logic [WB_DATA_W-1:0]  cmd_dat_i;
  logic [3:0]            cmd_sel_i;
  logic                  rsp_valid_o;
  logic [WB_DATA_W-1:0]  rsp_dat_o;
  status_t               rsp_status_o;

  // Wishbone side
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [3:0]            wb_sel_o;
  logic [WB_DATA_W-1:0]  wb_dat_o;
  logic                  wb_ack_i;
  logic                  wb_err_i;
  logic                  wb_rty_i;
  logic                  wb_stall_i;
  logic [WB_DATA_W-1:0]  wb_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
  );

endinterface

// File: rtl/wb_reg_master.sv
// Single-outstanding pipelined Wishbone initiator. Takes one command on a
// valid/ready handshake, runs one bus cycle (with retry on rty and a
// per-attempt timeout) and returns a one-cycle response pulse.
module wb_reg_master
  import wb_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int RETRY_MAX  = 3
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  wb_reg_master_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [TW-1:0] TCNT_MAX = TW'(TIMEOUT);
  localparam logic [RW-1:0] RCNT_MAX = RW'(RETRY_MAX);

  state_e                state_reg, state_next;
  logic [TW-1:0]         tcnt_reg, tcnt_next, tcnt_inc;
  logic [RW-1:0]         rcnt_reg, rcnt_next;
  logic                  ready_reg;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [WB_DATA_W-1:0]  rsp_dat_reg, rsp_dat_next;
  status_t               rsp_status_reg, rsp_status_next;
  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] adr_reg;
  logic [3:0]            sel_reg;
  logic [WB_DATA_W-1:0]  dat_reg;
  logic                  cmd_accept;

  assign cmd_accept = bus.cmd_valid_i && ready_reg;

  // tcnt_inc is the number of cyc-high cycles of this attempt including the
  // current one, so the timeout fires after exactly TIMEOUT cycles of cyc.
  assign tcnt_inc = (tcnt_reg == TCNT_MAX) ? tcnt_reg : tcnt_reg + 1'b1;

  // Next-state, counters and response: err beats ack beats rty beats timeout.
  always_comb begin
    state_next      = state_reg;
    tcnt_next       = tcnt_reg;
    rcnt_next       = rcnt_reg;
    rsp_valid_next  = 1'b0;
    rsp_dat_next    = rsp_dat_reg;
    rsp_status_next = rsp_status_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_accept) begin
          state_next = STROBE;
          tcnt_next  = '0;
          rcnt_next  = '0;
        end
      end
      STROBE, WAIT: begin
        tcnt_next = tcnt_inc;
        if (state_reg == STROBE && !bus.wb_stall_i) begin
          state_next = WAIT;
        end
        if (bus.wb_err_i) begin
          state_next      = IDLE;
          rsp_valid_next  = 1'b1;
          rsp_status_next = ST_ERR;
          rsp_dat_next    = '0;
        end else if (bus.wb_ack_i) begin
          state_next      = IDLE;
          rsp_valid_next  = 1'b1;
          rsp_status_next = ST_OK;
          rsp_dat_next    = we_reg ? '0 : bus.wb_dat_i;
        end else if (bus.wb_rty_i) begin
          if (rcnt_reg < RCNT_MAX) begin
            state_next = GAP;
            rcnt_next  = rcnt_reg + 1'b1;
            tcnt_next  = '0;
          end else begin
            state_next      = IDLE;
            rsp_valid_next  = 1'b1;
            rsp_status_next = ST_RETRY;
            rsp_dat_next    = '0;
          end
        end else if (tcnt_inc == TCNT_MAX) begin
          state_next      = IDLE;
          rsp_valid_next  = 1'b1;
          rsp_status_next = ST_TIMEOUT;
          rsp_dat_next    = '0;
        end
      end
      GAP: begin
        // one cyc-low cycle between attempts, then re-issue the held command
        state_next = STROBE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counters, handshake ready and response registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg      <= IDLE;
      tcnt_reg       <= '0;
      rcnt_reg       <= '0;
      ready_reg      <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_dat_reg    <= '0;
      rsp_status_reg <= ST_OK;
    end else begin
      state_reg      <= state_next;
      tcnt_reg       <= tcnt_next;
      rcnt_reg       <= rcnt_next;
      ready_reg      <= (state_next == IDLE);
      rsp_valid_reg  <= rsp_valid_next;
      rsp_dat_reg    <= rsp_dat_next;
      rsp_status_reg <= rsp_status_next;
    end
  end

  // Capture the command on acceptance; held through retries and in IDLE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_reg  <= 1'b0;
      adr_reg <= '0;
      sel_reg <= '0;
      dat_reg <= '0;
    end else if (cmd_accept) begin
      we_reg  <= bus.cmd_we_i;
      adr_reg <= bus.cmd_adr_i;
      sel_reg <= bus.cmd_sel_i;
      dat_reg <= bus.cmd_we_i ? bus.cmd_dat_i : '0;
    end
  end

  // cyc/stb decode straight from the state flop so reset drops them at once.
  assign bus.wb_cyc_o     = (state_reg == STROBE) || (state_reg == WAIT);
  assign bus.wb_stb_o     = (state_reg == STROBE);
  assign bus.wb_we_o      = we_reg;
  assign bus.wb_adr_o     = adr_reg;
  assign bus.wb_sel_o     = sel_reg;
  assign bus.wb_dat_o     = dat_reg;
  assign bus.cmd_ready_o  = ready_reg;
  assign bus.rsp_valid_o  = rsp_valid_reg;
  assign bus.rsp_dat_o    = rsp_dat_reg;
  assign bus.rsp_status_o = rsp_status_reg;

endmodule

// File: tb/tb_wb_reg_master.sv
// Directed bench for wb_reg_master (TIMEOUT=10, RETRY_MAX=3). Inputs are
// driven and outputs sampled on the falling clock edge; cycle 0 is the cycle
// in which cmd_valid_i is presented.
module tb_wb_reg_master;
  import wb_master_pkg::*;

  localparam int AW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  logic        use_bank = 1'b0;
  logic        t_ack = 1'b0, t_err = 1'b0, t_rty = 1'b0, t_stall = 1'b0;
  logic [31:0] t_dat = '0;
  logic [15:0] bank_reg = '0;
  int          bank_cnt = 0;
  logic        bank_ack;

  wb_reg_master_if #(.ADDR_WIDTH(AW)) bus ();

  wb_reg_master #(.ADDR_WIDTH(AW), .TIMEOUT(10), .RETRY_MAX(3)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Register-bank slave model: stalls until it acks, acks on the 2nd stb cycle,
  // one 16-bit register at address 0 (upper read half is filler).
  assign bank_ack       = bus.wb_cyc_o && bus.wb_stb_o && (bank_cnt == 1);
  assign bus.wb_ack_i   = use_bank ? bank_ack : t_ack;
  assign bus.wb_stall_i = use_bank ? (bus.wb_stb_o && !bank_ack) : t_stall;
  assign bus.wb_err_i   = use_bank ? 1'b0 : t_err;
  assign bus.wb_rty_i   = use_bank ? 1'b0 : t_rty;
  assign bus.wb_dat_i   = use_bank ? {16'hA5A5, bank_reg} : t_dat;

  always @(posedge clk) begin
    if (bus.wb_cyc_o && bus.wb_stb_o) bank_cnt <= bank_cnt + 1;
    else bank_cnt <= 0;
    if (use_bank && bank_ack && bus.wb_we_o && bus.wb_adr_o == '0) begin
      if (bus.wb_sel_o[0]) bank_reg[7:0]  <= bus.wb_dat_o[7:0];
      if (bus.wb_sel_o[1]) bank_reg[15:8] <= bus.wb_dat_o[15:8];
    end
  end

  task automatic clear_slave();
    t_ack = 1'b0; t_err = 1'b0; t_rty = 1'b0; t_stall = 1'b0; t_dat = '0;
  endtask

  task automatic issue(input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    bus.cmd_sel_i   = sel;
  endtask

  task automatic test_reset();
    bus.cmd_valid_i = 1'b0; bus.cmd_we_i = 1'b0; bus.cmd_adr_i = '0;
    bus.cmd_dat_i = '0; bus.cmd_sel_i = '0;
    clear_slave();
    #2 rst_n = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.cmd_ready_o, bus.rsp_valid_o} !== 4'b0000) begin
      err_cnt++;
      $display("FAIL reset_ctl got=%b exp=0000", {bus.wb_cyc_o, bus.wb_stb_o, bus.cmd_ready_o, bus.rsp_valid_o});
    end
    vec_cnt++;
    if ({bus.wb_adr_o, bus.wb_dat_o, bus.rsp_dat_o, bus.rsp_status_o} !== '0) begin
      err_cnt++;
      $display("FAIL reset_data got adr=%h dat=%h rsp=%h st=%b exp all 0",
               bus.wb_adr_o, bus.wb_dat_o, bus.rsp_dat_o, bus.rsp_status_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (bus.cmd_ready_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_ready got=%b exp=1", bus.cmd_ready_o);
    end
    // stray terminations in IDLE must be ignored
    t_ack = 1'b1; t_err = 1'b1;
    @(negedge clk);
    clear_slave();
    @(negedge clk);
    vec_cnt++;
    if ({bus.rsp_valid_o, bus.wb_cyc_o, bus.cmd_ready_o} !== 3'b001) begin
      err_cnt++;
      $display("FAIL stray_ack got=%b exp=001", {bus.rsp_valid_o, bus.wb_cyc_o, bus.cmd_ready_o});
    end
    $display("txn reset done");
  endtask

  task automatic test_bank_write_read();
    use_bank = 1'b1;
    issue(1'b1, 32'h0, 32'hDEADBEEF, 4'hF);
    @(negedge clk);                                   // cycle 1
    bus.cmd_valid_i = 1'b0;
    vec_cnt++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.cmd_ready_o} !== 4'b1110 ||
        bus.wb_dat_o !== 32'hDEADBEEF || bus.wb_adr_o !== 32'h0) begin
      err_cnt++;
      $display("FAIL wr_issue got ctl=%b dat=%h adr=%h exp ctl=1110 dat=deadbeef adr=0",
               {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.cmd_ready_o}, bus.wb_dat_o, bus.wb_adr_o);
    end
    @(negedge clk);                                   // cycle 2: ack
    vec_cnt++;
    if (bus.rsp_valid_o !== 1'b0 || bus.wb_stb_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL wr_c2 got rsp=%b stb=%b exp rsp=0 stb=1", bus.rsp_valid_o, bus.wb_stb_o);
    end
    @(negedge clk);                                   // cycle 3: response
    vec_cnt++;
    if ({bus.rsp_valid_o, bus.wb_cyc_o, bus.cmd_ready_o} !== 3'b101 ||
        bus.rsp_status_o !== ST_OK || bus.rsp_dat_o !== 32'h0) begin
      err_cnt++;
      $display("FAIL wr_rsp got v/cyc/rdy=%b st=%b dat=%h exp 101 st=00 dat=0",
               {bus.rsp_valid_o, bus.wb_cyc_o, bus.cmd_ready_o}, bus.rsp_status_o, bus.rsp_dat_o);
    end
    $display("txn write adr=0 dat=deadbeef status=%b", bus.rsp_status_o);
    @(negedge clk);
    vec_cnt++;
    if (bus.rsp_valid_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL wr_pulse got=%b exp=0", bus.rsp_valid_o);
    end
    issue(1'b0, 32'h0, 32'hCAFEF00D, 4'hF);           // readback
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    vec_cnt++;
    if (bus.wb_we_o !== 1'b0 || bus.wb_dat_o !== 32'h0) begin
      err_cnt++;
      $display("FAIL rd_wdat got we=%b dat=%h exp we=0 dat=0", bus.wb_we_o, bus.wb_dat_o);
    end
    @(negedge clk);
    @(negedge clk);
    vec_cnt++;
    if (bus.rsp_valid_o !== 1'b1 || bus.rsp_dat_o[15:0] !== 16'hBEEF || bus.rsp_status_o !== ST_OK) begin
      err_cnt++;
      $display("FAIL readback got v=%b dat=%h st=%b exp v=1 dat=????beef st=00",
               bus.rsp_valid_o, bus.rsp_dat_o, bus.rsp_status_o);
    end
    $display("txn read adr=0 dat=%h status=%b", bus.rsp_dat_o, bus.rsp_status_o);
    @(negedge clk);
    use_bank = 1'b0;
  endtask

  task automatic test_read_stall();
    logic [10:1] stb_vec, rsp_vec;
    issue(1'b0, 32'h100, 32'h0, 4'h3);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      stb_vec[c] = bus.wb_stb_o;
      rsp_vec[c] = bus.rsp_valid_o;
      if (c == 1) begin
        vec_cnt++;
        if (bus.wb_adr_o !== 32'h100 || bus.wb_sel_o !== 4'h3) begin
          err_cnt++;
          $display("FAIL rd_adr got adr=%h sel=%h exp adr=100 sel=3", bus.wb_adr_o, bus.wb_sel_o);
        end
      end
      t_stall = (c <= 5);
      t_ack   = (c == 8);
      t_dat   = (c == 8) ? 32'h12345678 : 32'h0;
    end
    clear_slave();
    vec_cnt++;
    if (stb_vec !== 10'b0000111111) begin
      err_cnt++;
      $display("FAIL rd_stb_len got=%b exp=0000111111", stb_vec);
    end
    vec_cnt++;
    if (rsp_vec !== 10'b0100000000) begin
      err_cnt++;
      $display("FAIL rd_rsp_cycle got=%b exp=0100000000", rsp_vec);
    end
    vec_cnt++;
    if (bus.rsp_dat_o !== 32'h12345678 || bus.rsp_status_o !== ST_OK) begin
      err_cnt++;
      $display("FAIL rd_data got dat=%h st=%b exp dat=12345678 st=00", bus.rsp_dat_o, bus.rsp_status_o);
    end
    $display("txn read adr=100 dat=%h status=%b", bus.rsp_dat_o, bus.rsp_status_o);
  endtask

  task automatic test_err_ack();
    issue(1'b0, 32'h20, 32'h0, 4'hF);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    t_err = 1'b1; t_ack = 1'b1; t_dat = 32'hFFFFFFFF;
    @(negedge clk);
    clear_slave();
    vec_cnt++;
    if (bus.rsp_valid_o !== 1'b1 || bus.rsp_status_o !== ST_ERR || bus.rsp_dat_o !== 32'h0 || bus.wb_cyc_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL err_ack got v=%b st=%b dat=%h cyc=%b exp v=1 st=01 dat=0 cyc=0",
               bus.rsp_valid_o, bus.rsp_status_o, bus.rsp_dat_o, bus.wb_cyc_o);
    end
    $display("txn read adr=20 status=%b (err+ack)", bus.rsp_status_o);
    @(negedge clk);
  endtask

  task automatic test_retry();
    logic [10:1] cyc_vec, stb_vec, rsp_vec, rdy_vec;
    issue(1'b1, 32'h40, 32'h55, 4'hF);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      cyc_vec[c] = bus.wb_cyc_o;
      stb_vec[c] = bus.wb_stb_o;
      rsp_vec[c] = bus.rsp_valid_o;
      rdy_vec[c] = bus.cmd_ready_o;
      t_rty = bus.wb_stb_o;
    end
    clear_slave();
    vec_cnt++;
    if (cyc_vec !== 10'b0001010101 || stb_vec !== 10'b0001010101) begin
      err_cnt++;
      $display("FAIL rty_phases got cyc=%b stb=%b exp both 0001010101", cyc_vec, stb_vec);
    end
    vec_cnt++;
    if (rsp_vec !== 10'b0010000000 || rdy_vec !== 10'b1110000000) begin
      err_cnt++;
      $display("FAIL rty_rsp got rsp=%b rdy=%b exp rsp=0010000000 rdy=1110000000", rsp_vec, rdy_vec);
    end
    vec_cnt++;
    if (bus.rsp_status_o !== ST_RETRY || bus.rsp_dat_o !== 32'h0 || bus.wb_adr_o !== 32'h40) begin
      err_cnt++;
      $display("FAIL rty_status got st=%b dat=%h adr=%h exp st=11 dat=0 adr=40",
               bus.rsp_status_o, bus.rsp_dat_o, bus.wb_adr_o);
    end
    $display("txn write adr=40 status=%b (retries)", bus.rsp_status_o);
  endtask

  task automatic test_timeout();
    logic [13:1] cyc_vec, rsp_vec, rdy_vec;
    issue(1'b0, 32'h80, 32'h0, 4'hF);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      cyc_vec[c] = bus.wb_cyc_o;
      rsp_vec[c] = bus.rsp_valid_o;
      rdy_vec[c] = bus.cmd_ready_o;
    end
    vec_cnt++;
    if (cyc_vec !== 13'b0001111111111) begin
      err_cnt++;
      $display("FAIL to_cyc_len got=%b exp=0001111111111", cyc_vec);
    end
    vec_cnt++;
    if (rsp_vec !== 13'b0010000000000 || rdy_vec !== 13'b1110000000000) begin
      err_cnt++;
      $display("FAIL to_rsp got rsp=%b rdy=%b exp rsp=0010000000000 rdy=1110000000000", rsp_vec, rdy_vec);
    end
    vec_cnt++;
    if (bus.rsp_status_o !== ST_TIMEOUT || bus.rsp_dat_o !== 32'h0) begin
      err_cnt++;
      $display("FAIL to_status got st=%b dat=%h exp st=10 dat=0", bus.rsp_status_o, bus.rsp_dat_o);
    end
    $display("txn read adr=80 status=%b (timeout)", bus.rsp_status_o);
  endtask

  task automatic test_reset_mid();
    int rsp_seen = 0;
    issue(1'b1, 32'h8, 32'h11, 4'hF);
    @(negedge clk);                                   // cycle 1: issued
    bus.cmd_valid_i = 1'b0;
    @(negedge clk);                                   // cycle 2: WAIT
    vec_cnt++;
    if ({bus.wb_cyc_o, bus.wb_stb_o} !== 2'b10) begin
      err_cnt++;
      $display("FAIL mid_wait got cyc/stb=%b exp=10", {bus.wb_cyc_o, bus.wb_stb_o});
    end
    #1 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({bus.wb_cyc_o, bus.wb_stb_o} !== 2'b00) begin
      err_cnt++;
      $display("FAIL mid_async got cyc/stb=%b exp=00", {bus.wb_cyc_o, bus.wb_stb_o});
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      if (bus.rsp_valid_o !== 1'b0) rsp_seen++;
    end
    vec_cnt++;
    if (rsp_seen != 0 || bus.cmd_ready_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL mid_norsp got pulses=%0d rdy=%b exp pulses=0 rdy=1", rsp_seen, bus.cmd_ready_o);
    end
    issue(1'b1, 32'h8, 32'h22, 4'hF);                 // fresh write, zero-wait ack
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    t_ack = 1'b1;
    @(negedge clk);
    clear_slave();
    vec_cnt++;
    if (bus.rsp_valid_o !== 1'b1 || bus.rsp_status_o !== ST_OK || bus.wb_cyc_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL post_reset_wr got v=%b st=%b cyc=%b exp v=1 st=00 cyc=0",
               bus.rsp_valid_o, bus.rsp_status_o, bus.wb_cyc_o);
    end
    $display("txn write adr=8 status=%b (after reset)", bus.rsp_status_o);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_bank_write_read();
    test_read_stall();
    test_err_ack();
    test_retry();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
